// File: rtl/fetch_pipeline_ctrl_if.sv
// Fetch-side interface: hazard/redirect controls coming in, instruction memory
// port, the IF/ID register contents going out, and the debug counters.
interface fetch_pipeline_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             PCSrcE;
  logic [31:0]      PCTargetE;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_rdata;
  logic [31:0]      PCF;
  logic [31:0]      InstrD;
  logic [31:0]      PCD;
  logic [31:0]      PCPlus4D;
  logic             ValidD;
  logic             misalign_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // The pipeline environment (hazard unit, execute stage, imem).
  modport master (
    output StallF, StallD, FlushD, PCSrcE, PCTargetE, imem_rdata,
    input  imem_addr, PCF, InstrD, PCD, PCPlus4D, ValidD,
           misalign_err, stall_cnt, flush_cnt
  );

  // The fetch controller itself.
  modport slave (
    input  StallF, StallD, FlushD, PCSrcE, PCTargetE, imem_rdata,
    output imem_addr, PCF, InstrD, PCD, PCPlus4D, ValidD,
           misalign_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_pipeline_ctrl.sv
// Fetch-stage controller: owns the PC and the IF/ID register, applies stall,
// flush and redirect decisions, and keeps saturating stall/flush event counters.
module fetch_pipeline_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input logic                 clk,
  input logic                 rst,
  fetch_pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    PC_STEP     = 2'd0,
    PC_HOLD     = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    IFID_LOAD  = 2'd0,
    IFID_HOLD  = 2'd1,
    IFID_FLUSH = 2'd2
  } ifid_sel_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{
    instr:    NOP_INSTR,
    pc:       32'h0,
    pc_plus4: 32'h0,
    valid:    1'b0
  };

  logic [31:0]      pc_q,        pc_d;
  ifid_t            ifid_q,      ifid_d;
  logic             misalign_q,  misalign_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  pc_sel_e          pc_sel;
  ifid_sel_e        ifid_sel;
  logic [31:0]      pc_plus4;
  logic [31:0]      redirect_pc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             en);
    return (en && !(&cnt)) ? cnt + 1'b1 : cnt;
  endfunction

  // A redirect outranks a fetch stall; a flush outranks a decode stall.
  always_comb begin
    pc_sel = PC_STEP;
    if (bus.PCSrcE)      pc_sel = PC_REDIRECT;
    else if (bus.StallF) pc_sel = PC_HOLD;

    ifid_sel = IFID_LOAD;
    if (bus.FlushD)      ifid_sel = IFID_FLUSH;
    else if (bus.StallD) ifid_sel = IFID_HOLD;
  end

  assign pc_plus4    = pc_q + 32'd4;
  assign redirect_pc = {bus.PCTargetE[31:2], 2'b00};

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    pc_d        = pc_q;
    ifid_d      = ifid_q;
    misalign_d  = misalign_q;
    stall_cnt_d = sat_inc(stall_cnt_q, bus.StallF);
    flush_cnt_d = sat_inc(flush_cnt_q, bus.FlushD);

    unique case (pc_sel)
      PC_REDIRECT: pc_d = redirect_pc;
      PC_HOLD:     pc_d = pc_q;
      default:     pc_d = pc_plus4;
    endcase

    unique case (ifid_sel)
      IFID_FLUSH: ifid_d = IFID_BUBBLE;
      IFID_HOLD:  ifid_d = ifid_q;
      default: begin
        ifid_d.instr    = bus.imem_rdata;
        ifid_d.pc       = pc_q;
        ifid_d.pc_plus4 = pc_plus4;
        ifid_d.valid    = 1'b1;
      end
    endcase

    if (bus.PCSrcE && (bus.PCTargetE[1:0] != 2'b00)) misalign_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every register sees
  // the pre-edge values of the others, matching real flop behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the IF/ID register resets to a bubble so decode never sees
      // stale data; the reset value is a legal no-op, not just zero.
      pc_q        <= RESET_PC;
      ifid_q      <= IFID_BUBBLE;
      misalign_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      ifid_q      <= ifid_d;
      misalign_q  <= misalign_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.PCF          = pc_q;
  assign bus.InstrD       = ifid_q.instr;
  assign bus.PCD          = ifid_q.pc;
  assign bus.PCPlus4D     = ifid_q.pc_plus4;
  assign bus.ValidD       = ifid_q.valid;
  assign bus.misalign_err = misalign_q;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_fetch_pipeline_ctrl.sv
// Self-checking bench for fetch_pipeline_ctrl: a rule-level model compared on
// every cycle, plus directed scenarios with literal expected values.
module tb_fetch_pipeline_ctrl;

  localparam int          CNT_W   = 4;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_pipeline_ctrl_if #(.CNT_W(CNT_W)) ifc ();

  fetch_pipeline_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP),
    .CNT_W     (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // Instruction memory contents: a fixed, address-dependent pattern.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign ifc.imem_rdata = imem_word(ifc.imem_addr);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each edge applies the written rules to the model state.
  logic [31:0] m_pcf, m_instr, m_pcd, m_pc4;
  logic        m_valid, m_mis;
  int          m_scnt, m_fcnt;
  bit          m_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pcf = 32'h0; m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h0;
      m_valid = 1'b0; m_mis = 1'b0; m_scnt = 0; m_fcnt = 0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      if (ifc.FlushD) begin
        m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (!ifc.StallD) begin
        m_instr = imem_word(m_pcf); m_pcd = m_pcf; m_pc4 = m_pcf + 32'd4; m_valid = 1'b1;
      end
      if (ifc.PCSrcE)       m_pcf = ifc.PCTargetE & 32'hFFFF_FFFC;
      else if (!ifc.StallF) m_pcf = m_pcf + 32'd4;
      if (ifc.PCSrcE && (ifc.PCTargetE % 4 != 0)) m_mis = 1'b1;
      if (ifc.StallF) m_scnt = (m_scnt + 1 > CNT_MAX) ? CNT_MAX : m_scnt + 1;
      if (ifc.FlushD) m_fcnt = (m_fcnt + 1 > CNT_MAX) ? CNT_MAX : m_fcnt + 1;
    end
  end

  // Every-cycle comparison, on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      check("cyc PCF",          ifc.PCF,                m_pcf);
      check("cyc imem_addr",    ifc.imem_addr,          m_pcf);
      check("cyc InstrD",       ifc.InstrD,             m_instr);
      check("cyc PCD",          ifc.PCD,                m_pcd);
      check("cyc PCPlus4D",     ifc.PCPlus4D,           m_pc4);
      check("cyc ValidD",       {31'b0, ifc.ValidD},    {31'b0, m_valid});
      check("cyc misalign_err", {31'b0, ifc.misalign_err}, {31'b0, m_mis});
      check("cyc stall_cnt",    {28'b0, ifc.stall_cnt}, 32'(m_scnt));
      check("cyc flush_cnt",    {28'b0, ifc.flush_cnt}, 32'(m_fcnt));
    end
  end

  // One clock: apply inputs, take the edge, return just after it.
  task automatic cycle(input logic r, input logic sf, input logic sd, input logic fl,
                       input logic ps, input logic [31:0] tgt);
    rst = r; ifc.StallF = sf; ifc.StallD = sd; ifc.FlushD = fl;
    ifc.PCSrcE = ps; ifc.PCTargetE = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifc.StallF = 1'b0; ifc.StallD = 1'b0; ifc.FlushD = 1'b0;
    ifc.PCSrcE = 1'b0; ifc.PCTargetE = 32'h0;

    // T1: reset two cycles, then free-running fetch.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("T1 reset PCF",    ifc.PCF,    32'h0);
    check("T1 reset InstrD", ifc.InstrD, NOP);
    check("T1 reset ValidD", {31'b0, ifc.ValidD}, 32'h0);
    run(1);
    check("T1 PCF c1",   ifc.PCF,    32'h4);
    check("T1 InstrD c1", ifc.InstrD, 32'hC0DE_0000);
    check("T1 ValidD c1", {31'b0, ifc.ValidD}, 32'h1);
    run(2);
    check("T1 PCF c3",      ifc.PCF,      32'hC);
    check("T1 InstrD c3",   ifc.InstrD,   32'hC0DE_0008);
    check("T1 PCD c3",      ifc.PCD,      32'h8);
    check("T1 PCPlus4D c3", ifc.PCPlus4D, 32'hC);
    run(1);

    // T2: PCF=0x10, full stall for three cycles.
    check("T2 PCF start", ifc.PCF, 32'h10);
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("T2 PCF held",   ifc.PCF,    32'h10);
    check("T2 PCD held",   ifc.PCD,    32'hC);
    check("T2 InstrD held", ifc.InstrD, 32'hC0DE_000C);
    check("T2 stall_cnt",  {28'b0, ifc.stall_cnt}, 32'd3);
    run(1);
    check("T2 PCF release", ifc.PCF, 32'h14);
    run(3);

    // T3: redirect + flush + stalls in the same cycle from PCF=0x20.
    check("T3 PCF start", ifc.PCF, 32'h20);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
    check("T3 PCF",       ifc.PCF,    32'h100);
    check("T3 InstrD",    ifc.InstrD, NOP);
    check("T3 ValidD",    {31'b0, ifc.ValidD}, 32'h0);
    check("T3 flush_cnt", {28'b0, ifc.flush_cnt}, 32'd1);
    check("T3 stall_cnt", {28'b0, ifc.stall_cnt}, 32'd4);
    run(2);

    // T4: misaligned redirect, error stays set.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h203);
    check("T4 PCF",      ifc.PCF, 32'h200);
    check("T4 misalign", {31'b0, ifc.misalign_err}, 32'h1);
    run(3);
    check("T4 misalign sticky", {31'b0, ifc.misalign_err}, 32'h1);

    // StallF only: the same word is reloaded into IF/ID.
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("SF-only PCF",    ifc.PCF,    32'h20C);
    check("SF-only PCD",    ifc.PCD,    32'h20C);
    check("SF-only InstrD", ifc.InstrD, 32'hC0DE_020C);
    // StallD only: PC advances, IF/ID holds.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("SD-only PCF", ifc.PCF, 32'h210);
    check("SD-only PCD", ifc.PCD, 32'h20C);
    // Flush without redirect.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("FL-only ValidD", {31'b0, ifc.ValidD}, 32'h0);
    check("FL-only PCF",    ifc.PCF, 32'h214);

    // T5: wrap of PC at the top of the address space.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("T5 PCF top", ifc.PCF, 32'hFFFF_FFFC);
    run(1);
    check("T5 PCF wrap",  ifc.PCF,      32'h0);
    check("T5 PCD",       ifc.PCD,      32'hFFFF_FFFC);
    check("T5 PCPlus4D",  ifc.PCPlus4D, 32'h0);

    // T6: counter saturation, then reset in the middle of activity.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("T6 misalign cleared", {31'b0, ifc.misalign_err}, 32'h0);
    repeat (20) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    check("T6 stall_cnt sat", {28'b0, ifc.stall_cnt}, 32'd15);
    check("T6 flush_cnt sat", {28'b0, ifc.flush_cnt}, 32'd15);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0777);
    check("T6 rst stall_cnt", {28'b0, ifc.stall_cnt}, 32'd0);
    check("T6 rst flush_cnt", {28'b0, ifc.flush_cnt}, 32'd0);
    check("T6 rst PCF",       ifc.PCF,    32'h0);
    check("T6 rst InstrD",    ifc.InstrD, NOP);
    check("T6 rst misalign",  {31'b0, ifc.misalign_err}, 32'h0);
    run(2);
    check("T6 post-rst PCF", ifc.PCF, 32'h8);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
